pool_collector: RTL and testbench

POOL_COLLECTOR -- requirements
Module: pool_collector

---
 rtl/pool_collector.sv | 75 +++++++
 tb/tb_pool_collector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pool_collector.sv
// pool_collector: buffers one frame of pooled samples, then streams it out over a valid/ready handshake
module pool_collector #(
  parameter int FRAME_SIZE = 121,
  parameter int DATA_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     collector_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     overflow
);
  localparam int IW = $clog2(FRAME_SIZE + 1);
  localparam logic [IW-1:0] LAST = IW'(FRAME_SIZE - 1);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state;
  logic [IW-1:0] wr_idx, rd_idx;
  logic signed [DATA_W-1:0] mem [FRAME_SIZE];
  logic write, load, done;
  assign write = state == FILL && valid_in;
  assign done = state == DRAIN && out_valid && out_ready && out_last;
  assign load = state == DRAIN && (!out_valid || (out_ready && !out_last));
  always_ff @(posedge clk)
    if (write) mem[wr_idx] <= data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_idx <= '0;
      rd_idx <= '0;
      collector_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (valid_in && state != FILL) overflow <= 1'b1;
      case (state)
        IDLE: begin
          state <= FILL;
          wr_idx <= '0;
          collector_ready <= 1'b1;
        end
        FILL: if (valid_in) begin
          wr_idx <= wr_idx + 1'b1;
          if (wr_idx == LAST) begin
            state <= DRAIN;
            rd_idx <= '0;
            collector_ready <= 1'b0;
          end
        end
        DRAIN: if (done) begin
          out_valid <= 1'b0;
          out_last <= 1'b0;
          frame_done <= 1'b1;
          state <= FILL;
          wr_idx <= '0;
          collector_ready <= 1'b1;
        end else if (load) begin
          out_data <= mem[rd_idx];
          out_last <= rd_idx == LAST;
          out_valid <= 1'b1;
          rd_idx <= rd_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_collector.sv
// tb_pool_collector: randomized scoreboard bench with a frame-level reference model
module tb_pool_collector;
  localparam int N = 121;
  localparam int W = 23;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, out_ready = 1'b0;
  logic signed [W-1:0] data_in = '0;
  logic collector_ready, out_valid, out_last, frame_done, overflow;
  logic signed [W-1:0] out_data;
  typedef struct { logic signed [W-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];
  logic signed [W-1:0] frame_q[$];
  logic signed [W-1:0] vals [N];
  int compared = 0, mismatched = 0;
  bit m_fill = 0, m_idle = 0, m_draining = 0, m_ovf = 0, rand_rdy = 0;
  int m_left = 0;
  bit p_valid = 0, p_ready = 0, p_last_xfer = 0, p_mid_xfer = 0;
  pool_collector #(.FRAME_SIZE(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .collector_ready(collector_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .frame_done(frame_done), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic void check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      m_fill = 0; m_idle = 1; m_draining = 0; m_ovf = 0; m_left = 0;
      frame_q.delete();
      exp_q.delete();
    end else begin
      check("collector_ready", collector_ready, m_fill);
      check("overflow", overflow, m_ovf);
      if (valid_in) begin
        if (m_fill) begin
          frame_q.push_back(data_in);
          if (frame_q.size() == N) begin
            foreach (frame_q[i]) exp_q.push_back('{frame_q[i], i == N - 1});
            frame_q.delete();
            m_fill = 0; m_draining = 1; m_left = N;
          end
        end else m_ovf = 1;
      end
      if (m_draining && out_valid && out_ready) begin
        m_left--;
        if (m_left == 0) begin m_draining = 0; m_fill = 1; end
      end
      if (m_idle) begin m_idle = 0; m_fill = 1; end
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      p_valid = 0; p_ready = 0; p_last_xfer = 0; p_mid_xfer = 0;
    end else begin
      check("frame_done", frame_done, p_last_xfer);
      if (p_mid_xfer) check("no_bubble", out_valid, 1);
      if (p_valid && !p_ready) check("hold_valid", out_valid, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
        else begin
          check("out_data", out_data, exp_q[0].d);
          check("out_last", out_last, exp_q[0].l);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      p_last_xfer = out_valid && out_ready && out_last;
      p_mid_xfer = out_valid && out_ready && !out_last;
      p_valid = out_valid;
      p_ready = out_ready;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic do_reset;
    rst = 1; valid_in = 0;
    tick; tick;
    check("rst_ready", collector_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    rst = 0;
  endtask
  task automatic wait_fill;
    int n = 0;
    while (!m_fill && n < 3000) begin tick; n++; end
    if (!m_fill) check("wait_fill_timeout", n, 0);
  endtask
  task automatic wait_drain;
    int n = 0;
    while ((m_draining || exp_q.size() != 0) && n < 5000) begin tick; n++; end
    if (m_draining || exp_q.size() != 0) check("wait_drain_timeout", n, 0);
  endtask
  task automatic send(input int cnt, input bit random_gap);
    wait_fill;
    for (int i = 0; i < cnt; i++) begin
      valid_in = 1; data_in = vals[i];
      tick;
      valid_in = 0;
      repeat (random_gap ? $urandom_range(0, 2) : 1) tick;
    end
  endtask
  initial begin
    int n;
    do_reset;
    out_ready = 1;
    for (int k = 0; k < N; k++) vals[k] = W'(k - 60);
    send(N, 0);
    wait_drain;
    out_ready = 0;
    send(N, 0);
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    repeat (10) tick;
    check("stall_data", out_data, -60);
    out_ready = 1;
    wait_drain;
    rand_rdy = 1;
    for (int k = 0; k < N; k++) vals[k] = W'($urandom);
    vals[0] = 23'h3FFFFF; vals[1] = 23'h400000;
    send(N, 1);
    wait_drain;
    for (int k = 0; k < N; k++) vals[k] = W'($urandom);
    vals[N-2] = 23'h400000; vals[N-1] = 23'h3FFFFF;
    send(N, 1);
    wait_drain;
    rand_rdy = 0;
    out_ready = 0;
    for (int k = 0; k < N; k++) vals[k] = W'(3 * k - 100);
    send(N, 0);
    repeat (3) begin
      valid_in = 1; data_in = W'(777);
      tick;
      valid_in = 0;
      tick;
    end
    check("overflow_set", overflow, 1);
    out_ready = 1;
    wait_drain;
    for (int k = 0; k < N; k++) vals[k] = W'(500 - k);
    send(N, 1);
    wait_drain;
    check("overflow_sticky", overflow, 1);
    do_reset;
    for (int k = 0; k < N; k++) vals[k] = W'(k + 1000);
    send(50, 0);
    do_reset;
    for (int k = 0; k < N; k++) vals[k] = W'(-7 * k);
    send(N, 0);
    wait_drain;
    check("overflow_clear", overflow, 0);
    repeat (5) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
